// File: rtl/mult_seq32_pkg.sv
// Shared constants, state encoding and operand helper for the sequential
// 32x32 multiplier.
package mult_seq32_pkg;

   localparam int WIDTH      = 32;
   localparam int ITER_COUNT = 32;
   localparam int CNT_W      = $clog2(ITER_COUNT);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      NEG  = 2'd2,
      DONE = 2'd3
   } state_t;

   // Unsigned magnitude of an operand. In signed mode 0x80000000 maps to
   // 2^31, which still fits the unsigned 32-bit register.
   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                  input logic             sgn);
      return (sgn && v[WIDTH-1]) ? (~v + 1'b1) : v;
   endfunction

endpackage

// File: rtl/mult_seq32_add33.sv
// Iteration adder: two 32-bit operands, 33-bit result split into sum and
// carry-out.
module add33 (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] sum,
   output logic        carry
);

   assign {carry, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/mult_seq32.sv
// Sequential radix-2 shift-add multiplier, 32x32 -> 64, signed or unsigned,
// fixed 34-cycle result cadence.
//
//  state | meaning
//  IDLE  | waiting for start
//  RUN   | one shift-add iteration per cycle, 32 cycles
//  NEG   | apply product sign, load hi/lo
//  DONE  | result valid for one cycle, may accept a new start
module mult_seq32 #(
   parameter int WIDTH = mult_seq32_pkg::WIDTH
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              is_signed,
   input  logic [WIDTH-1:0]  a,
   input  logic [WIDTH-1:0]  b,
   output logic              busy,
   output logic              done,
   output logic [WIDTH-1:0]  hi,
   output logic [WIDTH-1:0]  lo
);
   import mult_seq32_pkg::*;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH-1:0]   mcand;
   logic [WIDTH-1:0]   acc;
   logic [WIDTH-1:0]   mplier;
   logic               neg_sign;

   logic [WIDTH-1:0]   sum;
   logic               cout;
   logic               step_c;
   logic [WIDTH-1:0]   step_s;
   logic [2*WIDTH-1:0] product;

   add33 u_add (
      .a     (acc),
      .b     (mcand),
      .sum   (sum),
      .carry (cout)
   );

   // {step_c, step_s} is the 33-bit upper accumulator before the shift;
   // the shift pushes the carry into acc[31] and step_s[0] into the multiplier.
   always_comb begin
      step_c = 1'b0;
      step_s = acc;
      if (mplier[0]) begin
         step_c = cout;
         step_s = sum;
      end
   end

   assign product = {acc, mplier};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         mcand    <= '0;
         acc      <= '0;
         mplier   <= '0;
         neg_sign <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         hi       <= '0;
         lo       <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  mcand    <= magnitude(a, is_signed);
                  mplier   <= magnitude(b, is_signed);
                  acc      <= '0;
                  neg_sign <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                  cnt      <= '0;
                  busy     <= 1'b1;
                  state    <= RUN;
               end else begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            RUN: begin
               acc    <= {step_c, step_s[WIDTH-1:1]};
               mplier <= {step_s[0], mplier[WIDTH-1:1]};
               cnt    <= cnt + 1'b1;
               if (cnt == CNT_W'(ITER_COUNT - 1)) begin
                  state <= NEG;
               end
            end
            NEG: begin
               {hi, lo} <= neg_sign ? (~product + 64'd1) : product;
               busy     <= 1'b0;
               done     <= 1'b1;
               state    <= DONE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mult_seq32.sv
// Scoreboard bench for mult_seq32: directed vectors push expected products,
// a negedge monitor pops and compares on every done pulse.
module tb_mult_seq32;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        is_signed;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int          n_vec  = 0;
   int          n_fail = 0;
   int          done_cnt = 0;
   logic [63:0] exp_q[$];
   logic [63:0] prev_res = 64'd0;

   mult_seq32 dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .is_signed (is_signed),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .done      (done),
      .hi        (hi),
      .lo        (lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!reset && done) begin
         done_cnt++;
         if (exp_q.size() == 0) begin
            chk("unexpected done", {hi, lo}, 64'hx);
         end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            chk("result hi", {32'd0, hi}, {32'd0, e[63:32]});
            chk("result lo", {32'd0, lo}, {32'd0, e[31:0]});
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic run_op(input logic sgn, input logic [31:0] x, input logic [31:0] y,
                         input logic [63:0] exp);
      int lat;
      bit seen;
      @(negedge clk);
      start = 1'b1; is_signed = sgn; a = x; b = y;
      exp_q.push_back(exp);
      @(negedge clk);
      start = 1'b0; a = '0; b = '0;
      lat = 1; seen = 0;
      while (!seen && lat <= 60) begin
         if (lat == 10) chk("hold during op", {hi, lo}, prev_res);
         if (done) seen = 1;
         else begin
            @(negedge clk);
            lat++;
         end
      end
      chk("latency", 64'(lat), 64'd34);
      prev_res = exp;
   endtask

   initial begin
      int d[2];
      int k;
      reset = 1'b1; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
      #12;
      chk("reset busy", {63'd0, busy}, 64'd0);
      chk("reset done", {63'd0, done}, 64'd0);
      chk("reset hi/lo", {hi, lo}, 64'd0);
      @(negedge clk);
      reset = 1'b0;

      // 3*5 with cycle-exact busy/done profile; start is issued on the
      // first edge after reset release.
      start = 1'b1; a = 32'd3; b = 32'd5; is_signed = 1'b0;
      exp_q.push_back(64'd15);
      for (int c = 1; c <= 36; c++) begin
         @(negedge clk);
         start = 1'b0;
         chk($sformatf("busy c%0d", c), {63'd0, busy}, {63'd0, (c <= 33)});
         chk($sformatf("done c%0d", c), {63'd0, done}, {63'd0, (c == 34)});
         if (c == 20) chk("hold 3*5", {hi, lo}, 64'd0);
      end
      prev_res = 64'd15;
      chk("hold after done", {hi, lo}, 64'd15);

      run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
      run_op(1'b1, 32'hFFFF_FFFE, 32'd3,         64'hFFFF_FFFF_FFFF_FFFA);
      run_op(1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
      run_op(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001);
      run_op(1'b0, 32'h8000_0000, 32'd2,         64'h0000_0001_0000_0000);
      run_op(1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000);
      run_op(1'b1, 32'hFFFF_FFFF, 32'd2,         64'hFFFF_FFFF_FFFF_FFFE);

      // Start while busy must be dropped.
      @(negedge clk);
      start = 1'b1; is_signed = 1'b0; a = 32'd2; b = 32'd2;
      exp_q.push_back(64'd4);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      start = 1'b1; a = 32'd7; b = 32'd9;
      @(negedge clk);
      start = 1'b0;
      k = done_cnt;
      repeat (60) @(negedge clk);
      chk("ignored start done count", 64'(done_cnt - k), 64'd1);
      chk("ignored start result", {hi, lo}, 64'd4);
      prev_res = 64'd4;

      // Back-to-back with start held high.
      @(negedge clk);
      start = 1'b1; a = 32'd6; b = 32'd7;
      exp_q.push_back(64'd42);
      @(negedge clk);
      a = 32'd10; b = 32'd10;
      exp_q.push_back(64'd100);
      k = 0; d[0] = 0; d[1] = 0;
      for (int c = 1; c <= 80 && k < 2; c++) begin
         if (done) begin
            d[k] = c;
            k++;
         end else if (k == 1 && start) begin
            start = 1'b0;
            chk("accepted in DONE", {63'd0, busy}, 64'd1);
         end
         if (k < 2) @(negedge clk);
      end
      start = 1'b0;
      chk("b2b done pulses", 64'(k), 64'd2);
      chk("b2b spacing", 64'(d[1] - d[0]), 64'd34);
      prev_res = 64'd100;

      // Reset mid-operation.
      @(negedge clk);
      start = 1'b1; a = 32'd9; b = 32'd9;
      @(negedge clk);
      start = 1'b0;
      repeat (19) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("mid reset busy", {63'd0, busy}, 64'd0);
      chk("mid reset done", {63'd0, done}, 64'd0);
      chk("mid reset hi/lo", {hi, lo}, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      k = done_cnt;
      repeat (40) @(negedge clk);
      chk("no done after reset", 64'(done_cnt - k), 64'd0);
      prev_res = 64'd0;
      run_op(1'b0, 32'd4, 32'd4, 64'd16);

      repeat (3) @(negedge clk);
      chk("scoreboard drained", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/mult_seq32.md
MULT_SEQ32 -- requirements
Module: mult_seq32

Interface
REQ-001 Parameter: WIDTH, default 32, operand width; only 32 is supported.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: start  input  1  request a multiply; sampled on the rising clk edge.
REQ-005 Port: is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-006 Port: a  input  32  multiplicand; sampled with start.
REQ-007 Port: b  input  32  multiplier; sampled with start.
REQ-008 Port: busy  output  1  high while a multiply is in progress.
REQ-009 Port: done  output  1  one-cycle pulse; hi/lo hold a new result.
REQ-010 Port: hi  output  32  upper 32 bits of the 64-bit product.
REQ-011 Port: lo  output  32  lower 32 bits of the 64-bit product.

Function
REQ-012 FSM states SHALL be IDLE, RUN, NEG and DONE.
REQ-013 In IDLE or DONE, start=1 SHALL capture a, b and is_signed, load the operand magnitudes, record the product sign (a[31]^b[31] when signed, else 0), clear the iteration count to 0, and go to RUN.
REQ-014 In IDLE or DONE, start=0 SHALL go to or stay in IDLE.
REQ-015 RUN SHALL perform one radix-2 shift-add iteration per cycle: add the multiplicand to the 33-bit upper accumulator when the multiplier LSB is 1, then shift the {carry, acc, multiplier} word right by one.
REQ-016 RUN SHALL last exactly 32 cycles, then go to NEG.
REQ-017 NEG SHALL last one cycle and SHALL two's-complement negate the 64-bit magnitude when the recorded sign is 1.
REQ-018 The NEG-to-DONE edge SHALL write the 64-bit result into hi/lo.
REQ-019 hi/lo SHALL hold their value at all other times, including during a following operation.
REQ-020 done SHALL be 1 only in DONE, i.e. 34 cycles after the accepting edge; latency is independent of operand values and sign.
REQ-021 busy SHALL be 1 in RUN and NEG and 0 in IDLE and DONE.
REQ-022 start while busy=1 SHALL be ignored: no operand capture and no effect on the operation in progress.
REQ-023 start in DONE SHALL be accepted, allowing back-to-back operations with one result every 34 cycles.
REQ-024 Signed magnitude of 0x80000000 SHALL be 2^31, carried in the 33-bit datapath without overflow.
REQ-025 Unsigned mode SHALL treat bit 31 as magnitude.

Reset
REQ-026 Asserting reset SHALL, without a clock edge, force IDLE and set busy=0, done=0, hi=0, lo=0, the iteration count to 0 and all working registers to 0.
REQ-027 Reset asserted mid-operation SHALL abandon the operation; no done pulse SHALL follow.
REQ-028 The first start SHALL be accepted on the first rising edge after reset deasserts.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding, WIDTH=32 and ITER_COUNT=32.
REQ-030 One sub-module, add33, SHALL implement the 33-bit iteration adder (32-bit operands, carry-out).
REQ-031 FSM, counter, sign handling and output registers SHALL remain in mult_seq32.

Verification
REQ-032 Unsigned 3*5, start at edge 0 -> done=1 in cycle 34 with hi=0x00000000, lo=0x0000000F; busy=1 in cycles 1-33.
REQ-033 Unsigned 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-034 Signed (-2)*3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA; signed 0x80000000*0x80000000 -> hi=0x40000000, lo=0x00000000.
REQ-035 start with a=7, b=9 at cycle 5 of a running 2*2 -> first result hi=0, lo=4 with a single done pulse; the 7*9 request is discarded.
REQ-036 Back-to-back: start held high, 6*7 then 10*10 -> done pulses 34 cycles apart with lo=42 then lo=100.
REQ-037 Reset pulse in cycle 20 of a running operation -> busy=0, hi=0, lo=0 immediately and no done pulse afterwards; a following 4*4 returns lo=16.
